// File: rtl/cpu_memresp.sv
// -----------------------------------------------------------------------------
// cpu_memresp
//
// Memory-side responder for the Intel 8008 external bus. Every CLK2_I edge
// with SYNC_I=1 is a bus-state strobe: STATE_I tells which CPU state is
// current and DAT_I carries whatever the CPU drives in it. The responder
// collects the 14-bit address from the T1 (low byte) and T2 (high bits plus
// cycle type) strobes, hands the access to a simple request/ack memory port,
// and completes the CPU side in T3 by either driving read data or capturing
// write data. An interrupt-acknowledge fetch (T1I) is answered from
// INT_VEC_I without touching memory.
//
// Ports
//   CLK2_I      clock, all flops rise on it
//   nRST_I      asynchronous active-low reset
//   SYNC_I      state strobe qualifier for STATE_I / DAT_I
//   STATE_I     CPU state code {S2,S1,S0}
//   DAT_I       CPU data bus (CPU driving)
//   DAT_O       read data toward the CPU, zero when DAT_OE_O is low
//   DAT_OE_O    responder drives the CPU bus (read T3 only)
//   READY_O     to CPU READY, low holds the CPU in WAIT
//   INT_VEC_I   instruction jammed onto the bus for a T1I fetch
//   MEM_ADDR_O  latched address {AH[5:0], AL[7:0]}
//   MEM_RD_O    one-cycle read request
//   MEM_WR_O    one-cycle write request
//   MEM_DAT_O   write data for memory
//   MEM_DAT_I   read data from memory, valid with MEM_ACK_I
//   MEM_ACK_I   single-cycle memory completion pulse
// -----------------------------------------------------------------------------
module cpu_memresp (
    input  logic        CLK2_I,
    input  logic        nRST_I,
    input  logic        SYNC_I,
    input  logic [2:0]  STATE_I,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    output logic        DAT_OE_O,
    output logic        READY_O,
    input  logic [7:0]  INT_VEC_I,
    output logic [13:0] MEM_ADDR_O,
    output logic        MEM_RD_O,
    output logic        MEM_WR_O,
    output logic [7:0]  MEM_DAT_O,
    input  logic [7:0]  MEM_DAT_I,
    input  logic        MEM_ACK_I
);

    // CPU state codes {S2,S1,S0}
    localparam logic [2:0] ST_T1   = 3'b010;
    localparam logic [2:0] ST_T1I  = 3'b110;
    localparam logic [2:0] ST_T2   = 3'b100;
    localparam logic [2:0] ST_T3   = 3'b001;
    localparam logic [2:0] ST_STOP = 3'b011;

    // Cycle type carried in DAT_I[7:6] of the T2 strobe
    localparam logic [1:0] CYC_PCI = 2'b00;
    localparam logic [1:0] CYC_PCR = 2'b01;
    localparam logic [1:0] CYC_PCC = 2'b10;
    localparam logic [1:0] CYC_PCW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_H  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_HOLD = 3'd3,
        S_WR_DATA = 3'd4,
        S_WR_WAIT = 3'd5
    } fsm_t;

    fsm_t        state_r;
    logic [7:0]  al_r;        // low address byte from T1/T1I
    logic [5:0]  ah_r;        // high address bits from T2
    logic        inta_r;      // current cycle began with T1I
    logic        pend_r;      // a T1/T1I arrived while a write was still open
    logic [7:0]  rdata_r;     // data latch returned to the CPU in T3
    logic        ready_r;
    logic        mem_rd_r;
    logic        mem_wr_r;
    logic [7:0]  mem_dat_r;

    logic        t1_strobe_s;
    logic        t1i_s;
    logic        t2_strobe_s;
    logic        t3_strobe_s;
    logic        stop_strobe_s;
    logic        dat_oe_s;

    // Strobe decode: a state only counts on an edge qualified by SYNC_I
    always_comb begin
        t1_strobe_s   = 1'b0;
        t1i_s         = 1'b0;
        t2_strobe_s   = 1'b0;
        t3_strobe_s   = 1'b0;
        stop_strobe_s = 1'b0;
        if (SYNC_I) begin
            t1_strobe_s   = (STATE_I == ST_T1) || (STATE_I == ST_T1I);
            t1i_s         = (STATE_I == ST_T1I);
            t2_strobe_s   = (STATE_I == ST_T2);
            t3_strobe_s   = (STATE_I == ST_T3);
            stop_strobe_s = (STATE_I == ST_STOP);
        end else begin
            t1_strobe_s   = 1'b0;
        end
    end

    // Bus-cycle sequencer; request pulses default low and are set for one cycle
    always_ff @(posedge CLK2_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_r   <= S_IDLE;
            al_r      <= 8'h00;
            ah_r      <= 6'h00;
            inta_r    <= 1'b0;
            pend_r    <= 1'b0;
            rdata_r   <= 8'h00;
            ready_r   <= 1'b1;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            mem_dat_r <= 8'h00;
        end else begin
            mem_rd_r <= 1'b0;
            mem_wr_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (t1_strobe_s) begin
                        al_r    <= DAT_I;
                        inta_r  <= t1i_s;
                        state_r <= S_ADDR_H;
                    end
                end

                S_ADDR_H: begin
                    if (t1_strobe_s) begin
                        // CPU restarted the cycle: take the new low byte
                        al_r    <= DAT_I;
                        inta_r  <= t1i_s;
                        state_r <= S_ADDR_H;
                    end else if (stop_strobe_s) begin
                        state_r <= S_IDLE;
                    end else if (t2_strobe_s) begin
                        ah_r <= DAT_I[5:0];
                        case (DAT_I[7:6])
                            CYC_PCI, CYC_PCR: begin
                                if (inta_r) begin
                                    // Interrupt fetch is served from the vector
                                    rdata_r <= INT_VEC_I;
                                    state_r <= S_RD_HOLD;
                                end else begin
                                    mem_rd_r <= 1'b1;
                                    ready_r  <= 1'b0;
                                    state_r  <= S_RD_WAIT;
                                end
                            end
                            CYC_PCC: state_r <= S_IDLE;
                            CYC_PCW: state_r <= S_WR_DATA;
                            default: state_r <= S_IDLE;
                        endcase
                    end
                end

                S_RD_WAIT: begin
                    // Only the ack moves us on; WAIT/STOPPED strobes are ignored
                    if (MEM_ACK_I) begin
                        rdata_r <= MEM_DAT_I;
                        ready_r <= 1'b1;
                        state_r <= S_RD_HOLD;
                    end
                end

                S_RD_HOLD: begin
                    if (t1_strobe_s) begin
                        al_r    <= DAT_I;
                        inta_r  <= t1i_s;
                        state_r <= S_ADDR_H;
                    end else if (t3_strobe_s || stop_strobe_s) begin
                        state_r <= S_IDLE;
                    end
                end

                S_WR_DATA: begin
                    if (t1_strobe_s) begin
                        al_r    <= DAT_I;
                        inta_r  <= t1i_s;
                        state_r <= S_ADDR_H;
                    end else if (stop_strobe_s) begin
                        state_r <= S_IDLE;
                    end else if (t3_strobe_s) begin
                        mem_dat_r <= DAT_I;
                        mem_wr_r  <= 1'b1;
                        ready_r   <= 1'b0;
                        state_r   <= S_WR_WAIT;
                    end
                end

                S_WR_WAIT: begin
                    // The next T1 may overtake the slow write: remember its
                    // low byte now, but hold READY low until memory is done.
                    if (t1_strobe_s) begin
                        al_r   <= DAT_I;
                        inta_r <= t1i_s;
                        pend_r <= 1'b1;
                    end
                    if (MEM_ACK_I) begin
                        ready_r <= 1'b1;
                        pend_r  <= 1'b0;
                        state_r <= (pend_r || t1_strobe_s) ? S_ADDR_H : S_IDLE;
                    end
                end

                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    // Bus drive enable follows STATE_I directly so it tracks the CPU's T3 window
    always_comb begin
        dat_oe_s = 1'b0;
        if (state_r == S_RD_HOLD) begin
            dat_oe_s = (STATE_I == ST_T3);
        end else begin
            dat_oe_s = 1'b0;
        end
    end

    assign DAT_OE_O   = dat_oe_s;
    assign DAT_O      = dat_oe_s ? rdata_r : 8'h00;
    assign READY_O    = ready_r;
    assign MEM_ADDR_O = {ah_r, al_r};
    assign MEM_RD_O   = mem_rd_r;
    assign MEM_WR_O   = mem_wr_r;
    assign MEM_DAT_O  = mem_dat_r;

endmodule

// File: tb/tb_cpu_memresp.sv
module tb_cpu_memresp;

    localparam logic [2:0] T1 = 3'b010, T1I = 3'b110, T2 = 3'b100, TW = 3'b000;
    localparam logic [2:0] T3 = 3'b001, TSTOP = 3'b011, T4 = 3'b111, T5 = 3'b101;

    logic        CLK2_I = 1'b0;
    logic        nRST_I;
    logic        SYNC_I;
    logic [2:0]  STATE_I;
    logic [7:0]  DAT_I;
    logic [7:0]  DAT_O;
    logic        DAT_OE_O;
    logic        READY_O;
    logic [7:0]  INT_VEC_I;
    logic [13:0] MEM_ADDR_O;
    logic        MEM_RD_O;
    logic        MEM_WR_O;
    logic [7:0]  MEM_DAT_O;
    logic [7:0]  MEM_DAT_I;
    logic        MEM_ACK_I;

    cpu_memresp dut (
        .CLK2_I(CLK2_I), .nRST_I(nRST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .DAT_OE_O(DAT_OE_O), .READY_O(READY_O),
        .INT_VEC_I(INT_VEC_I), .MEM_ADDR_O(MEM_ADDR_O), .MEM_RD_O(MEM_RD_O),
        .MEM_WR_O(MEM_WR_O), .MEM_DAT_O(MEM_DAT_O), .MEM_DAT_I(MEM_DAT_I),
        .MEM_ACK_I(MEM_ACK_I)
    );

    always #5 CLK2_I = ~CLK2_I;

    int total = 0;
    int bad   = 0;

    // physical memory behind the port, and the reference model's view of it
    logic [7:0] dev_mem [16384];
    logic [7:0] ref_mem [16384];

    // memory responder / monitor state
    int          ack_delay = 1;
    bit          pend = 1'b0;
    int          wait_left;
    logic        is_wr;
    logic [13:0] ra;
    logic [7:0]  rwd;
    int          rd_cnt, wr_cnt, oe_cnt, rlow_cnt, zbad_cnt;
    logic [7:0]  dout_seen, wdat_seen;

    typedef struct {
        logic [1:0]  typ;
        logic        inta;
        logic [7:0]  al;
        logic [5:0]  ah;
        logic [7:0]  vec;
        logic [7:0]  wd;
        logic        pre;
        logic [7:0]  pv;
        int          d;
        logic [13:0] e_addr;
        int          e_rd;
        int          e_wr;
        int          e_oe;
        logic [7:0]  e_dout;
        logic [7:0]  e_wdat;
        int          e_rlow;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; rlow_cnt = 0; zbad_cnt = 0;
        dout_seen = 8'h00; wdat_seen = 8'h00;
    endtask

    // memory side: ack arrives in the d-th cycle counting the request cycle as 1
    initial begin
        MEM_ACK_I = 1'b0;
        MEM_DAT_I = 8'h00;
        clr_mon();
        forever begin
            @(negedge CLK2_I);
            MEM_ACK_I = 1'b0;
            if (MEM_RD_O) rd_cnt++;
            if (MEM_WR_O) begin wr_cnt++; wdat_seen = MEM_DAT_O; end
            if (DAT_OE_O) begin oe_cnt++; dout_seen = DAT_O; end
            else if (DAT_O !== 8'h00) zbad_cnt++;
            if (!READY_O) rlow_cnt++;
            if (MEM_RD_O || MEM_WR_O) begin
                pend = 1'b1; wait_left = ack_delay; is_wr = MEM_WR_O;
                ra = MEM_ADDR_O; rwd = MEM_DAT_O;
            end
            if (pend) begin
                wait_left--;
                if (wait_left <= 0) begin
                    MEM_ACK_I = 1'b1;
                    if (is_wr) dev_mem[ra] = rwd;
                    else MEM_DAT_I = dev_mem[ra];
                    pend = 1'b0;
                end
            end
        end
    end

    // one bus state: inputs change just after a rising edge, sampled at the next
    task automatic cyc(input logic s, input logic [2:0] st, input logic [7:0] d);
        SYNC_I = s; STATE_I = st; DAT_I = d;
        @(posedge CLK2_I); #1;
    endtask

    // full CPU bus cycle as the CPU would run it
    task automatic bus_cycle(input vec_t v, output logic [13:0] o_addr, output bit o_tmo);
        ack_delay = v.d; INT_VEC_I = v.vec; o_tmo = 1'b0;
        clr_mon();
        cyc(1'b1, v.inta ? T1I : T1, v.al);
        cyc(1'b1, T2, {v.typ, v.ah});
        for (int k = 0; k < 40 && READY_O == 1'b0; k++) cyc(1'b1, TW, 8'h00);
        if (READY_O !== 1'b1) o_tmo = 1'b1;
        o_addr = MEM_ADDR_O;
        cyc(1'b1, T3, (v.typ == 2'b11) ? v.wd : 8'($urandom));
        for (int k = 0; k < 40 && READY_O == 1'b0; k++) cyc(1'b0, T4, 8'h00);
        if (READY_O !== 1'b1) o_tmo = 1'b1;
        cyc(1'b0, T5, 8'h00);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [13:0] a;
        bit          tmo;
        if (v.pre) begin
            dev_mem[{v.ah, v.al}] = v.pv;
            ref_mem[{v.ah, v.al}] = v.pv;
        end
        bus_cycle(v, a, tmo);
        if (v.typ == 2'b11) ref_mem[{v.ah, v.al}] = v.wd;
        chk({tag, ".timeout"}, 32'(tmo), 32'd0);
        chk({tag, ".addr"}, 32'(a), 32'(v.e_addr));
        chk({tag, ".rd_pulses"}, rd_cnt, v.e_rd);
        chk({tag, ".wr_pulses"}, wr_cnt, v.e_wr);
        chk({tag, ".oe_cycles"}, oe_cnt, v.e_oe);
        chk({tag, ".dat_o"}, 32'(dout_seen), 32'(v.e_dout));
        chk({tag, ".mem_dat_o"}, 32'(wdat_seen), 32'(v.e_wdat));
        chk({tag, ".ready_low"}, rlow_cnt, v.e_rlow);
        chk({tag, ".dat_o_zero"}, zbad_cnt, 0);
    endtask

    function automatic vec_t mk(logic [1:0] typ, logic inta, logic [7:0] al, logic [5:0] ah,
                                logic [7:0] vec, logic [7:0] wd, logic pre, logic [7:0] pv, int d,
                                logic [13:0] ea, int erd, int ewr, int eoe,
                                logic [7:0] edo, logic [7:0] ewd, int erl);
        vec_t v;
        v.typ = typ; v.inta = inta; v.al = al; v.ah = ah; v.vec = vec; v.wd = wd;
        v.pre = pre; v.pv = pv; v.d = d; v.e_addr = ea; v.e_rd = erd; v.e_wr = ewr;
        v.e_oe = eoe; v.e_dout = edo; v.e_wdat = ewd; v.e_rlow = erl;
        return v;
    endfunction

    // reference: what one bus cycle should do, from the cycle type rules
    function automatic vec_t model(logic [1:0] typ, logic inta, logic [7:0] al, logic [5:0] ah,
                                   logic [7:0] vec, logic [7:0] wd, int d);
        logic [13:0] a = {ah, al};
        bit is_read  = (typ == 2'b00) || (typ == 2'b01);
        bit goes_mem = (is_read && !inta) || (typ == 2'b11);
        logic [7:0] rd_val = inta ? vec : ref_mem[a];
        return mk(typ, inta, al, ah, vec, wd, 1'b0, 8'h00, d, a,
                  (is_read && !inta) ? 1 : 0, (typ == 2'b11) ? 1 : 0, is_read ? 1 : 0,
                  is_read ? rd_val : 8'h00, (typ == 2'b11) ? wd : 8'h00, goes_mem ? d : 0);
    endfunction

    vec_t tbl [8];

    initial begin
        vec_t v;
        logic [13:0] a;
        tbl[0] = mk(2'b01, 1'b0, 8'h34, 6'h12, 8'h00, 8'h00, 1'b1, 8'hA5, 3, 14'h1234, 1, 0, 1, 8'hA5, 8'h00, 3);
        tbl[1] = mk(2'b11, 1'b0, 8'hFF, 6'h3F, 8'h00, 8'h5A, 1'b0, 8'h00, 2, 14'h3FFF, 0, 1, 0, 8'h00, 8'h5A, 2);
        tbl[2] = mk(2'b00, 1'b1, 8'h00, 6'h00, 8'h0D, 8'h00, 1'b0, 8'h00, 3, 14'h0000, 0, 0, 1, 8'h0D, 8'h00, 0);
        tbl[3] = mk(2'b10, 1'b0, 8'h11, 6'h00, 8'h00, 8'h00, 1'b0, 8'h00, 3, 14'h0011, 0, 0, 0, 8'h00, 8'h00, 0);
        tbl[4] = mk(2'b00, 1'b0, 8'h00, 6'h00, 8'h00, 8'h00, 1'b1, 8'h76, 1, 14'h0000, 1, 0, 1, 8'h76, 8'h00, 1);
        tbl[5] = mk(2'b00, 1'b0, 8'hFF, 6'h3F, 8'h00, 8'h00, 1'b0, 8'h00, 1, 14'h3FFF, 1, 0, 1, 8'h5A, 8'h00, 1);
        tbl[6] = mk(2'b01, 1'b1, 8'h80, 6'h20, 8'hC7, 8'h00, 1'b0, 8'h00, 2, 14'h2080, 0, 0, 1, 8'hC7, 8'h00, 0);
        tbl[7] = mk(2'b11, 1'b0, 8'h01, 6'h01, 8'h00, 8'hC3, 1'b0, 8'h00, 6, 14'h0101, 0, 1, 0, 8'h00, 8'hC3, 6);

        for (int i = 0; i < 16384; i++) begin
            dev_mem[i] = 8'(i * 37 + (i >> 6));
            ref_mem[i] = dev_mem[i];
        end

        // reset state, with a T3 strobe present to show OE stays off
        nRST_I = 1'b0; INT_VEC_I = 8'h00;
        cyc(1'b1, T3, 8'hFF);
        cyc(1'b1, T3, 8'hFF);
        chk("rst.dat_o", 32'(DAT_O), 32'h00);
        chk("rst.dat_oe", 32'(DAT_OE_O), 32'h0);
        chk("rst.ready", 32'(READY_O), 32'h1);
        chk("rst.addr", 32'(MEM_ADDR_O), 32'h0);
        chk("rst.mem_rd", 32'(MEM_RD_O), 32'h0);
        chk("rst.mem_wr", 32'(MEM_WR_O), 32'h0);
        chk("rst.mem_dat", 32'(MEM_DAT_O), 32'h00);
        nRST_I = 1'b1;
        cyc(1'b0, T5, 8'h00);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // write with slow ack overtaken by the next T1, then a read
        dev_mem[14'h0120] = 8'h3C; ref_mem[14'h0120] = 8'h3C;
        clr_mon(); ack_delay = 5;
        cyc(1'b1, T1, 8'h10);
        cyc(1'b1, T2, 8'hC2);
        cyc(1'b1, T3, 8'h77);
        cyc(1'b1, T1, 8'h20);
        chk("b2b.new_al", 32'(MEM_ADDR_O), 32'h0220);
        chk("b2b.ready_held", 32'(READY_O), 32'h0);
        for (int k = 0; k < 40 && READY_O == 1'b0; k++) cyc(1'b1, T2, 8'h41);
        chk("b2b.wr_ready_low", rlow_cnt, 5);
        chk("b2b.wr_pulses", wr_cnt, 1);
        chk("b2b.wdat", 32'(wdat_seen), 32'h77);
        chk("b2b.mem_written", 32'(dev_mem[14'h0210]), 32'h77);
        ref_mem[14'h0210] = 8'h77;
        clr_mon(); ack_delay = 2;
        cyc(1'b1, T2, 8'h41);
        for (int k = 0; k < 40 && READY_O == 1'b0; k++) cyc(1'b1, TW, 8'h00);
        a = MEM_ADDR_O;
        cyc(1'b1, T3, 8'h00);
        cyc(1'b0, T5, 8'h00);
        chk("b2b.rd_addr", 32'(a), 32'h0120);
        chk("b2b.rd_pulses", rd_cnt, 1);
        chk("b2b.rd_data", 32'(dout_seen), 32'h3C);
        chk("b2b.rd_ready_low", rlow_cnt, 2);
        chk("b2b.oe_cycles", oe_cnt, 1);

        // resync: second T1 in ADDR_H replaces the low byte
        dev_mem[14'h0355] = 8'hE1; ref_mem[14'h0355] = 8'hE1;
        clr_mon(); ack_delay = 1;
        cyc(1'b1, T1, 8'hAA);
        cyc(1'b1, T1, 8'h55);
        cyc(1'b1, T2, 8'h43);
        for (int k = 0; k < 40 && READY_O == 1'b0; k++) cyc(1'b1, TW, 8'h00);
        a = MEM_ADDR_O;
        cyc(1'b1, T3, 8'h00);
        cyc(1'b0, T5, 8'h00);
        chk("resync.addr", 32'(a), 32'h0355);
        chk("resync.data", 32'(dout_seen), 32'hE1);

        // STOPPED after T1 abandons the cycle: the T2 that follows is ignored
        clr_mon();
        cyc(1'b1, T1, 8'h99);
        cyc(1'b1, TSTOP, 8'h00);
        cyc(1'b1, T2, 8'h40);
        cyc(1'b1, T3, 8'h00);
        cyc(1'b0, T5, 8'h00);
        chk("stop.rd_pulses", rd_cnt, 0);
        chk("stop.oe_cycles", oe_cnt, 0);
        chk("stop.ready_low", rlow_cnt, 0);

        // reset in RD_WAIT; the late ack must be ignored
        clr_mon(); ack_delay = 4;
        cyc(1'b1, T1, 8'h34);
        cyc(1'b1, T2, 8'h52);
        cyc(1'b1, TW, 8'h00);
        #2 nRST_I = 1'b0;
        #1;
        chk("rstmid.ready", 32'(READY_O), 32'h1);
        chk("rstmid.addr", 32'(MEM_ADDR_O), 32'h0);
        chk("rstmid.mem_rd", 32'(MEM_RD_O), 32'h0);
        chk("rstmid.dat_oe", 32'(DAT_OE_O), 32'h0);
        @(posedge CLK2_I); #1;
        nRST_I = 1'b1;
        clr_mon();
        for (int k = 0; k < 5; k++) cyc(1'b1, T3, 8'h00);
        chk("rstmid.late_ack_oe", oe_cnt, 0);
        chk("rstmid.late_ack_ready", rlow_cnt, 0);
        chk("rstmid.late_ack_addr", 32'(MEM_ADDR_O), 32'h0);
        cyc(1'b0, T5, 8'h00);
        run_vec(tbl[0], "rstmid.next_read");

        // randomized cycles against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] typ = 2'($urandom_range(0, 3));
            logic inta = ($urandom_range(0, 3) == 0);
            logic [7:0] al = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            logic [5:0] ah = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
            v = model(typ, inta, al, ah, 8'($urandom), 8'($urandom), int'($urandom_range(1, 6)));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
